// File: rtl/int_accum_unit_pkg.sv
// Shared types for the integer accumulator stage: handshake tokens, opcode layout, FSM encoding.
// Widths here fix the token layout seen by neighbouring data-flow elements.
package int_accum_unit_pkg;

    localparam int FTK_WIDTH_DATA    = 32;
    localparam int FTK_WIDTH_ID      = 8;
    localparam int WIDTH_ACC_DEFAULT = 48;
    localparam int WIDTH_CNT_DEFAULT = 16;

    typedef struct packed {
        logic                      v;
        logic                      a;
        logic                      r;
        logic                      c;
        logic [FTK_WIDTH_ID-1:0]   i;
        logic [FTK_WIDTH_DATA-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
        logic v;
        logic c;
    } BTk_t;

    // Bit 0 is the LSB of I_Opcode.
    typedef struct packed {
        logic rsvd;
        logic fwd_c;
        logic sat;
        logic sgn;
    } opcode_acc_t;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_ATTR  = 2'd1,
        ACC_ACCUM = 2'd2,
        ACC_EMIT  = 2'd3
    } acc_state_t;

endpackage

// File: rtl/int_accum_unit_saturate.sv
// Combinational clamp of the wide accumulator onto the result width.
// The clamp acts on the already-wrapped accumulator value.
module acc_saturate
    import int_accum_unit_pkg::*;
#(
    parameter int WIDTH_ACC  = WIDTH_ACC_DEFAULT,
    parameter int WIDTH_DATA = FTK_WIDTH_DATA
) (
    input  logic [WIDTH_ACC-1:0]  acc_in,
    input  logic                  sgn,
    input  logic                  sat,
    output logic [WIDTH_DATA-1:0] res_out
);

    localparam logic [WIDTH_DATA-1:0] S_MAX = {1'b0, {(WIDTH_DATA-1){1'b1}}};
    localparam logic [WIDTH_DATA-1:0] S_MIN = {1'b1, {(WIDTH_DATA-1){1'b0}}};
    localparam logic [WIDTH_DATA-1:0] U_MAX = '1;

    // Signed value fits only if the sign bit of the result and everything above it agree.
    logic [WIDTH_ACC-WIDTH_DATA:0]   top_s;
    logic [WIDTH_ACC-WIDTH_DATA-1:0] top_u;
    logic                            ovf_s;
    logic                            ovf_u;

    assign top_s = acc_in[WIDTH_ACC-1:WIDTH_DATA-1];
    assign top_u = acc_in[WIDTH_ACC-1:WIDTH_DATA];
    assign ovf_s = ~(&top_s) & (|top_s);
    assign ovf_u = |top_u;

    always_comb begin
        res_out = acc_in[WIDTH_DATA-1:0];
        if (sat) begin
            if (sgn) begin
                if (ovf_s) begin
                    res_out = acc_in[WIDTH_ACC-1] ? S_MIN : S_MAX;
                end
            end else if (ovf_u) begin
                res_out = U_MAX;
            end
        end
    end

endmodule

// File: rtl/int_accum_unit.sv
// Integer accumulator downstream of the multiplier: sums a run of product tokens
// and emits one (optionally saturated) result token per run.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | disabled, input ignored, no stall to upstream
// ST_ATTR   | waiting for the attribute word that opens a run (discarded)
// ST_ACCUM  | summing accepted products until .r or the programmed count
// ST_EMIT   | result token valid, upstream stalled until consumer takes it
module int_accum_unit
    import int_accum_unit_pkg::*;
#(
    parameter int WIDTH_DATA = FTK_WIDTH_DATA,
    parameter int WIDTH_ACC  = WIDTH_ACC_DEFAULT,
    parameter int WIDTH_CNT  = WIDTH_CNT_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 I_En,
    input  logic [3:0]           I_Opcode,
    input  logic [WIDTH_CNT-1:0] I_Length,
    input  FTk_t                 I_FTk,
    output BTk_t                 O_BTk,
    output FTk_t                 O_FTk,
    input  BTk_t                 I_BTk,
    output logic                 O_Busy
);

    localparam logic [1:0] ST_IDLE  = ACC_IDLE;
    localparam logic [1:0] ST_ATTR  = ACC_ATTR;
    localparam logic [1:0] ST_ACCUM = ACC_ACCUM;
    localparam logic [1:0] ST_EMIT  = ACC_EMIT;

    localparam logic [WIDTH_CNT-1:0] CNT_MAX = '1;

    opcode_acc_t op;

    logic [1:0]            state_q, state_d;
    logic [WIDTH_ACC-1:0]  acc_q, acc_d;
    logic [WIDTH_CNT-1:0]  cnt_q, cnt_d;
    FTk_t                  out_q, out_d;

    logic                  bwd_n;
    logic                  accept;
    logic [WIDTH_DATA-1:0] data_in;
    logic [WIDTH_ACC-1:0]  data_ext;
    logic [WIDTH_ACC-1:0]  acc_sum;
    logic [WIDTH_CNT-1:0]  cnt_inc;
    logic                  len_hit;
    logic                  close_run;
    logic [WIDTH_DATA-1:0] sat_res;
    logic                  unused_bits;

    assign op = opcode_acc_t'(I_Opcode);

    always_comb begin
        bwd_n = 1'b0;
        case (state_q)
            ST_EMIT:           bwd_n = 1'b1;
            ST_ATTR, ST_ACCUM: bwd_n = I_BTk.n;
            default:           bwd_n = 1'b0;
        endcase
    end

    assign accept = I_FTk.v & ~bwd_n;

    assign data_in  = I_FTk.d[WIDTH_DATA-1:0];
    assign data_ext = {{(WIDTH_ACC-WIDTH_DATA){op.sgn & data_in[WIDTH_DATA-1]}}, data_in};
    assign acc_sum  = acc_q + data_ext;

    // Counter sticks at all-ones; with I_Length=0 the run can only close on .r.
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + WIDTH_CNT'(1);
    assign len_hit   = (I_Length != '0) && ((cnt_q + WIDTH_CNT'(1)) == I_Length);
    assign close_run = I_FTk.r | len_hit;

    acc_saturate #(
        .WIDTH_ACC  (WIDTH_ACC),
        .WIDTH_DATA (WIDTH_DATA)
    ) u_sat (
        .acc_in  (acc_sum),
        .sgn     (op.sgn),
        .sat     (op.sat),
        .res_out (sat_res)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (I_En) begin
                    state_d = ST_ATTR;
                end
            end
            ST_ATTR: begin
                if (!I_En) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (accept) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (!I_En) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (accept) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                    if (close_run) begin
                        state_d = ST_EMIT;
                        out_d.v = 1'b0;
                        out_d.a = op.sgn & sat_res[WIDTH_DATA-1];
                        out_d.r = 1'b1;
                        out_d.c = op.fwd_c & I_FTk.c;
                        out_d.i = I_FTk.i;
                        out_d.d = FTK_WIDTH_DATA'(sat_res);
                    end
                end
            end
            ST_EMIT: begin
                // A pending result is always delivered, even if I_En has dropped.
                if (!I_BTk.n) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = I_En ? ST_ACCUM : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign O_BTk = '{n: bwd_n, t: I_BTk.t, v: I_BTk.v, c: I_BTk.c};

    assign O_FTk = '{v: (state_q == ST_EMIT), a: out_q.a, r: out_q.r,
                     c: out_q.c, i: out_q.i, d: out_q.d};

    assign O_Busy = (state_q != ST_IDLE);

    assign unused_bits = ^{out_q.v, op.rsvd, I_FTk.a};

endmodule

// File: tb/tb_int_accum_unit.sv
// Directed bench for int_accum_unit: expected result tokens are queued when a run's
// closing term is driven and compared when the DUT delivers a token.
module tb_int_accum_unit;
    import int_accum_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        I_En;
    logic [3:0]  I_Opcode;
    logic [15:0] I_Length;
    FTk_t        I_FTk;
    FTk_t        O_FTk;
    BTk_t        I_BTk;
    BTk_t        O_BTk;
    logic        O_Busy;

    int   nvec   = 0;
    int   nerr   = 0;
    int   n_push = 0;
    int   n_emit = 0;
    FTk_t exp_q[$];
    FTk_t exp_m;
    FTk_t hold_exp;

    always #5 clock = ~clock;

    int_accum_unit dut (
        .clock    (clock),
        .reset    (reset),
        .I_En     (I_En),
        .I_Opcode (I_Opcode),
        .I_Length (I_Length),
        .I_FTk    (I_FTk),
        .O_BTk    (O_BTk),
        .O_FTk    (O_FTk),
        .I_BTk    (I_BTk),
        .O_Busy   (O_Busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic FTk_t mk(input logic [31:0] d, input logic a, input logic c,
                                input logic [7:0] id);
        FTk_t t;
        t = '{v: 1'b1, a: a, r: 1'b1, c: c, i: id, d: d};
        return t;
    endfunction

    task automatic push_exp(input FTk_t t);
        exp_q.push_back(t);
        n_push++;
    endtask

    // Presents one product token (entered and left at a falling edge) until it is accepted.
    task automatic send(input logic [31:0] d, input logic rr, input logic cc, input logic [7:0] id);
        int guard;
        guard = 0;
        I_FTk = '{v: 1'b1, a: 1'b0, r: rr, c: cc, i: id, d: d};
        #1;
        while (O_BTk.n !== 1'b0 && guard < 50) begin
            @(negedge clock);
            #1;
            guard++;
        end
        if (guard >= 50) begin
            nvec++;
            nerr++;
            $display("FAIL send_timeout: observed stall held %0d cycles expected release", guard);
        end
        @(posedge clock);
        @(negedge clock);
        I_FTk = '0;
    endtask

    // Returns to IDLE, programs the run, re-enables and feeds the attribute word.
    task automatic start_run(input logic [3:0] op, input logic [15:0] len);
        I_En     = 1'b0;
        I_Opcode = op;
        I_Length = len;
        I_FTk    = '0;
        @(negedge clock);
        #1;
        chk("idle_busy", 64'(O_Busy), 64'd0);
        chk("idle_valid", 64'(O_FTk.v), 64'd0);
        I_En = 1'b1;
        @(negedge clock);
        send(32'hA77A_5EED, 1'b0, 1'b0, 8'hFF);
    endtask

    always @(negedge clock) begin
        #2;
        if (reset === 1'b0 && O_FTk.v === 1'b1 && I_BTk.n === 1'b0) begin
            n_emit++;
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $error("FAIL emit_unexpected: observed %h expected no token", O_FTk);
            end else begin
                exp_m = exp_q.pop_front();
                chk("emit", 64'(O_FTk), 64'(exp_m));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish before limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        I_En     = 1'b0;
        I_Opcode = 4'd0;
        I_Length = 16'd0;
        I_FTk    = '0;
        I_BTk    = '0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_oftk", 64'(O_FTk), 64'd0);
        chk("rst_obtk", 64'(O_BTk), 64'd0);
        chk("rst_busy", 64'(O_Busy), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // 1: unsigned, four terms, result one cycle after the last accept
        start_run(4'b0000, 16'd4);
        send(32'd3, 1'b0, 1'b0, 8'h01);
        send(32'd5, 1'b0, 1'b0, 8'h02);
        send(32'd7, 1'b0, 1'b0, 8'h03);
        chk("t1_pre_close", 64'(O_FTk.v), 64'd0);
        push_exp(mk(32'd24, 1'b0, 1'b0, 8'h11));
        send(32'd9, 1'b0, 1'b1, 8'h11);
        chk("t1_latency", 64'(O_FTk.v), 64'd1);
        chk("t1_stall_up", 64'(O_BTk.n), 64'd1);

        // 2: signed, closed by .r; .c not forwarded without opcode bit 2
        start_run(4'b0001, 16'd0);
        send(32'hFFFF_FFF6, 1'b0, 1'b0, 8'h20);
        send(32'd4, 1'b0, 1'b0, 8'h21);
        push_exp(mk(32'hFFFF_FFF9, 1'b1, 1'b0, 8'h22));
        send(32'hFFFF_FFFF, 1'b1, 1'b1, 8'h22);

        // 2b: I_Length=1 emits every product; .r with count-close emits once; .c forwarded
        start_run(4'b0101, 16'd1);
        push_exp(mk(32'd5, 1'b0, 1'b1, 8'h31));
        send(32'd5, 1'b0, 1'b1, 8'h31);
        push_exp(mk(32'd6, 1'b0, 1'b0, 8'h32));
        send(32'd6, 1'b0, 1'b0, 8'h32);
        push_exp(mk(32'd7, 1'b0, 1'b1, 8'h33));
        send(32'd7, 1'b1, 1'b1, 8'h33);

        // 3: signed saturate, plain signed wrap, unsigned saturate, negative saturate
        start_run(4'b0011, 16'd3);
        send(32'h7FFF_FFFF, 1'b0, 1'b0, 8'h40);
        send(32'h7FFF_FFFF, 1'b0, 1'b0, 8'h40);
        push_exp(mk(32'h7FFF_FFFF, 1'b0, 1'b0, 8'h41));
        send(32'h7FFF_FFFF, 1'b0, 1'b0, 8'h41);
        start_run(4'b0001, 16'd3);
        send(32'h7FFF_FFFF, 1'b0, 1'b0, 8'h40);
        send(32'h7FFF_FFFF, 1'b0, 1'b0, 8'h40);
        push_exp(mk(32'h7FFF_FFFD, 1'b0, 1'b0, 8'h42));
        send(32'h7FFF_FFFF, 1'b0, 1'b0, 8'h42);
        start_run(4'b0010, 16'd2);
        send(32'hFFFF_FFFF, 1'b0, 1'b0, 8'h43);
        push_exp(mk(32'hFFFF_FFFF, 1'b0, 1'b0, 8'h44));
        send(32'd2, 1'b0, 1'b0, 8'h44);
        start_run(4'b0011, 16'd2);
        send(32'h8000_0000, 1'b0, 1'b0, 8'h45);
        push_exp(mk(32'h8000_0000, 1'b1, 1'b0, 8'h46));
        send(32'h8000_0000, 1'b0, 1'b0, 8'h46);

        // 4: consumer stalls five cycles; next product is held upstream, not lost
        start_run(4'b0000, 16'd2);
        send(32'd10, 1'b0, 1'b0, 8'h50);
        hold_exp = mk(32'd30, 1'b0, 1'b0, 8'h51);
        push_exp(hold_exp);
        send(32'd20, 1'b0, 1'b0, 8'h51);
        I_BTk.n = 1'b1;
        I_FTk   = '{v: 1'b1, a: 1'b0, r: 1'b0, c: 1'b0, i: 8'h52, d: 32'd2};
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_hold_oftk", 64'(O_FTk), 64'(hold_exp));
            chk("t4_hold_obtk_n", 64'(O_BTk.n), 64'd1);
            @(negedge clock);
        end
        I_BTk.n = 1'b0;
        send(32'd2, 1'b0, 1'b0, 8'h52);
        push_exp(mk(32'd5, 1'b0, 1'b0, 8'h53));
        send(32'd3, 1'b0, 1'b0, 8'h53);

        // 5: enable drops mid-run, nothing emitted, no residue on rerun
        start_run(4'b0000, 16'd4);
        send(32'd100, 1'b0, 1'b0, 8'h60);
        send(32'd200, 1'b0, 1'b0, 8'h61);
        I_En = 1'b0;
        @(negedge clock);
        #1;
        chk("t5_abort_busy", 64'(O_Busy), 64'd0);
        chk("t5_abort_valid", 64'(O_FTk.v), 64'd0);
        start_run(4'b0000, 16'd4);
        send(32'd1, 1'b0, 1'b0, 8'h62);
        send(32'd1, 1'b0, 1'b0, 8'h62);
        send(32'd1, 1'b0, 1'b0, 8'h62);
        push_exp(mk(32'd4, 1'b0, 1'b0, 8'h63));
        send(32'd1, 1'b0, 1'b0, 8'h63);

        // 6: asynchronous reset mid-run, then a clean run
        start_run(4'b0000, 16'd4);
        send(32'd5, 1'b0, 1'b0, 8'h70);
        send(32'd6, 1'b0, 1'b0, 8'h71);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_rst_oftk", 64'(O_FTk), 64'd0);
        chk("t6_rst_obtk", 64'(O_BTk), 64'd0);
        chk("t6_rst_busy", 64'(O_Busy), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        start_run(4'b0000, 16'd2);
        send(32'd7, 1'b0, 1'b0, 8'h72);
        push_exp(mk(32'd15, 1'b0, 1'b0, 8'h73));
        send(32'd8, 1'b0, 1'b0, 8'h73);

        I_En = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(negedge clock);
        end
        @(negedge clock);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("emit_count", 64'(n_emit), 64'(n_push));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
